// File: rtl/uart_rx_fpga_link.sv
// FPGA-side deframer for the LArPix piso serial link: 2x oversampled UART, 64-bit frames.
// Optional sticky overrun flag enabled by defining UART_RX_OVERRUN_EN.
module uart_rx_fpga_link #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_rx,
  input  logic             reset_n,
  input  logic             rx_in,
  input  logic             uld_rx_data,
  input  logic             v3_mode,
  output logic [WIDTH-2:0] rx_data,
  output logic             rx_empty,
  output logic             parity_error
`ifdef UART_RX_OVERRUN_EN
  ,
  output logic             rx_overrun
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic             rx_meta_q;
  logic             rx_sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-2:0] rx_data_q, rx_data_d;
  logic             rx_empty_q, rx_empty_d;
  logic             parity_error_q, parity_error_d;
  logic             commit_c;

  // Frame sequencer; phase selects the second of the two samples in each bit time
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    shift_d   = shift_q;
    commit_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (!rx_sync_q) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          phase_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          shift_d = {rx_sync_q, shift_q[WIDTH-1:1]};
          if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      S_STOP: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (rx_sync_q) begin
            commit_c = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Consumer-facing registers; a commit overrides a same-cycle unload
  always_comb begin
    rx_data_d      = rx_data_q;
    parity_error_d = parity_error_q;
    rx_empty_d     = rx_empty_q;
    if (uld_rx_data) begin
      rx_empty_d = 1'b1;
    end
    if (commit_c) begin
      rx_data_d      = shift_q[WIDTH-2:0];
      parity_error_d = v3_mode ? (^shift_q) : (~^shift_q);
      rx_empty_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_rx or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q      <= 1'b1;
      rx_sync_q      <= 1'b1;
      state_q        <= S_IDLE;
      bit_cnt_q      <= '0;
      phase_q        <= 1'b0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_empty_q     <= 1'b1;
      parity_error_q <= 1'b0;
    end else begin
      rx_meta_q      <= rx_in;
      rx_sync_q      <= rx_meta_q;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      phase_q        <= phase_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_empty_q     <= rx_empty_d;
      parity_error_q <= parity_error_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_empty     = rx_empty_q;
  assign parity_error = parity_error_q;

`ifdef UART_RX_OVERRUN_EN
  logic rx_overrun_q, rx_overrun_d;

  // Set when a commit lands on an unread packet; set wins over a same-cycle unload
  always_comb begin
    rx_overrun_d = rx_overrun_q;
    if (uld_rx_data) begin
      rx_overrun_d = 1'b0;
    end
    if (commit_c && !rx_empty_q) begin
      rx_overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_rx or negedge reset_n) begin
    if (!reset_n) begin
      rx_overrun_q <= 1'b0;
    end else begin
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign rx_overrun = rx_overrun_q;
`endif

endmodule

// File: tb/tb_uart_rx_fpga_link.sv
// Directed self-checking bench for uart_rx_fpga_link (frames driven two clk_rx cycles per bit).
module tb_uart_rx_fpga_link;

  logic        clk_rx = 1'b0;
  logic        reset_n;
  logic        rx_in;
  logic        uld_rx_data;
  logic        v3_mode;
  logic [62:0] rx_data;
  logic        rx_empty;
  logic        parity_error;
`ifdef UART_RX_OVERRUN_EN
  logic        rx_overrun;
`endif

  int errors = 0;
  int checks = 0;

  uart_rx_fpga_link #(.WIDTH(64)) dut (
    .clk_rx      (clk_rx),
    .reset_n     (reset_n),
    .rx_in       (rx_in),
    .uld_rx_data (uld_rx_data),
    .v3_mode     (v3_mode),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .parity_error(parity_error)
`ifdef UART_RX_OVERRUN_EN
    ,
    .rx_overrun  (rx_overrun)
`endif
  );

  always #5 clk_rx = ~clk_rx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_rx);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    cycles(2);
  endtask

  task automatic send_frame(input logic [62:0] payload, input logic pbit, input logic stop);
    logic [63:0] frame;
    frame = {pbit, payload};
    send_bit(1'b0);
    for (int i = 0; i < 64; i++) send_bit(frame[i]);
    send_bit(stop);
    rx_in = 1'b1;
  endtask

  // Bounded wait for rx_empty to fall; a timeout is reported as a failed check
  task automatic wait_commit(input string tag);
    int n;
    n = 0;
    while (rx_empty !== 1'b0 && n < 20) begin
      @(negedge clk_rx);
      n++;
    end
    check(tag, 64'(rx_empty), 64'd0);
  endtask

  task automatic unload();
    uld_rx_data = 1'b1;
    cycles(2);
    uld_rx_data = 1'b0;
    cycles(1);
  endtask

  initial begin
    logic idle_bad;
    reset_n     = 1'b0;
    rx_in       = 1'b1;
    uld_rx_data = 1'b0;
    v3_mode     = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(1);

    // Reset state
    check("rst_empty", 64'(rx_empty), 64'd1);
    check("rst_data", 64'(rx_data), 64'd0);
    check("rst_perr", 64'(parity_error), 64'd0);
`ifdef UART_RX_OVERRUN_EN
    check("rst_ovr", 64'(rx_overrun), 64'd0);
`endif

    // Idle line for 1000 cycles must not disturb outputs
    idle_bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_rx);
      if (rx_empty !== 1'b1 || rx_data !== 63'd0 || parity_error !== 1'b0) idle_bad = 1'b1;
    end
    check("idle_1000", 64'(idle_bad), 64'd0);

    // 0x102 has two ones; parity bit 0 -> XOR of 64 bits = 0 -> odd check flags error
    send_frame(63'h102, 1'b0, 1'b1);
    wait_commit("f1_commit");
    check("f1_data", 64'(rx_data), 64'h102);
    check("f1_perr", 64'(parity_error), 64'd1);
    unload();
    check("f1_uld_empty", 64'(rx_empty), 64'd1);
    check("f1_uld_data", 64'(rx_data), 64'h102);

    // Parity bit 1 -> XOR = 1 -> odd parity good
    send_frame(63'h102, 1'b1, 1'b1);
    wait_commit("f2_commit");
    check("f2_data", 64'(rx_data), 64'h102);
    check("f2_perr", 64'(parity_error), 64'd0);
    unload();

    // Same frame under even check: XOR = 1 -> error
    v3_mode = 1'b1;
    send_frame(63'h102, 1'b1, 1'b1);
    wait_commit("f3_commit");
    check("f3_perr_v3", 64'(parity_error), 64'd1);
    unload();
    v3_mode = 1'b0;

    // Bad stop bit: frame dropped, outputs unchanged
    send_frame(63'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    cycles(12);
    check("bad_stop_empty", 64'(rx_empty), 64'd1);
    check("bad_stop_data", 64'(rx_data), 64'h102);

    // Valid frame after break: 0x1234 has five ones, parity bit 0 -> XOR=1 -> good
    send_frame(63'h1234, 1'b0, 1'b1);
    wait_commit("post_break_commit");
    check("post_break_data", 64'(rx_data), 64'h1234);
    check("post_break_perr", 64'(parity_error), 64'd0);
    unload();
`ifdef UART_RX_OVERRUN_EN
    check("ovr_clear", 64'(rx_overrun), 64'd0);
`endif

    // Back-to-back frames without unload; 0x1/0x2 with parity bit 0 -> XOR=1 -> good
    send_frame(63'h1, 1'b0, 1'b1);
    send_frame(63'h2, 1'b0, 1'b1);
    cycles(8);
    check("b2b_data", 64'(rx_data), 64'h2);
    check("b2b_empty", 64'(rx_empty), 64'd0);
    check("b2b_perr", 64'(parity_error), 64'd0);
`ifdef UART_RX_OVERRUN_EN
    check("b2b_ovr", 64'(rx_overrun), 64'd1);
`endif
    unload();
    check("b2b_uld_empty", 64'(rx_empty), 64'd1);

    // One-cycle low glitch on the idle line
    rx_in = 1'b0;
    cycles(1);
    rx_in = 1'b1;
    cycles(150);
    check("glitch_empty", 64'(rx_empty), 64'd1);
    check("glitch_data", 64'(rx_data), 64'h2);

    // Reset pulse in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 20; i++) send_bit(i[0]);
    reset_n = 1'b0;
    cycles(2);
    rx_in = 1'b1;
    reset_n = 1'b1;
    cycles(150);
    check("midrst_empty", 64'(rx_empty), 64'd1);
    check("midrst_data", 64'(rx_data), 64'd0);

    // 0x55 has four ones; parity bit 1 -> XOR=1 -> good
    send_frame(63'h55, 1'b1, 1'b1);
    wait_commit("f55_commit");
    check("f55_data", 64'(rx_data), 64'h55);
    check("f55_perr", 64'(parity_error), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
